dem_sv_sched: RTL

Element-selection scheduler for the 18-element unit DAC: accepts one quantizer level per sample and produces the 18-bit selection vector `SV` that drives the element array and the downstream transition detector. Supports static thermometer and rotating data-weighted-averaging (DWA) selection, buffers one level through a valid/ready handshake, and reports per-sample rising-transition count plus sticky overflow/underrun flags. Sits between the modulator output and the transition detector / element drivers, advancing only on the sample strobe `clk_en`.

---
 rtl/dem_sv_sched_pkg.sv | 29 ++
 rtl/dem_sv_sched_if.sv | 34 +++
 rtl/dem_sv_sched_dwa_mask_gen.sv | 65 ++++++
 rtl/dem_sv_sched.sv | 104 ++++++++++
 4 files changed

// File: rtl/dem_sv_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dem_pkg
// Brief    : Shared constants, mode encodings and helpers for dem_sv_sched.
// Revision : 1.0
// ============================================================================
package dem_pkg;

    localparam int N  = 18;
    localparam int LW = 5;

    typedef enum logic [1:0] {
        MODE_THERM  = 2'b00,
        MODE_DWA    = 2'b01,
        MODE_FREEZE = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    function automatic logic [LW-1:0] popcount(input logic [N-1:0] v);
        logic [LW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + {{(LW-1){1'b0}}, v[i]};
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dem_sv_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : dem_sv_sched_if
// Brief    : Level handshake, control and status bundle of the DEM scheduler.
// Revision : 1.0
// ============================================================================
interface dem_sv_sched_if;
    import dem_pkg::*;

    logic          clk_en;
    logic [LW-1:0] lvl_in;
    logic          lvl_valid;
    logic          lvl_ready;
    logic [1:0]    mode;
    logic          err_clr;
    logic [N-1:0]  SV;
    logic          sv_valid;
    logic [LW-1:0] tr_cnt;
    logic [LW-1:0] ptr;
    logic          ovf_err;
    logic          udr_err;

    modport master (
        output clk_en, lvl_in, lvl_valid, mode, err_clr,
        input  lvl_ready, SV, sv_valid, tr_cnt, ptr, ovf_err, udr_err
    );

    modport slave (
        input  clk_en, lvl_in, lvl_valid, mode, err_clr,
        output lvl_ready, SV, sv_valid, tr_cnt, ptr, ovf_err, udr_err
    );

endinterface
`default_nettype wire

// File: rtl/dem_sv_sched_dwa_mask_gen.sv
`default_nettype none
// ============================================================================
// Module   : dwa_mask_gen
// Brief    : Combinational selection-vector and next-pointer generator.
// Revision : 1.0
// ============================================================================
module dwa_mask_gen
    import dem_pkg::*;
(
    input  wire logic [LW-1:0] i_ptr,
    input  wire logic [LW-1:0] i_lvl,
    input  wire logic [1:0]    i_mode,
    input  wire logic [N-1:0]  i_sv_cur,
    output logic      [N-1:0]  o_sv_new,
    output logic      [LW-1:0] o_ptr_next
);

    localparam logic [LW:0] c_n_ext = (LW+1)'(N);

    logic [N-1:0] w_therm;
    logic [N-1:0] w_dwa;
    logic [LW:0]  w_ptr_ext;
    logic [LW:0]  w_lvl_ext;
    logic [LW:0]  w_sum;
    logic [LW:0]  w_sum_wrap;

    assign w_ptr_ext  = {1'b0, i_ptr};
    assign w_lvl_ext  = {1'b0, i_lvl};
    assign w_sum      = w_ptr_ext + w_lvl_ext;
    assign w_sum_wrap = (w_sum >= c_n_ext) ? (w_sum - c_n_ext) : w_sum;

    // Each element is selected when its distance past the pointer (mod N) is below L.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_bit
            localparam logic [LW:0] c_idx = (LW+1)'(gi);
            logic [LW:0] w_off;
            assign w_off       = (c_idx >= w_ptr_ext) ? (c_idx - w_ptr_ext)
                                                      : (c_idx + c_n_ext - w_ptr_ext);
            assign w_therm[gi] = (c_idx < w_lvl_ext);
            assign w_dwa[gi]   = (w_off < w_lvl_ext);
        end
    endgenerate

    always_comb begin
        o_sv_new   = i_sv_cur;
        o_ptr_next = i_ptr;
        case (mode_e'(i_mode))
            MODE_THERM: begin
                o_sv_new   = w_therm;
                o_ptr_next = '0;
            end
            MODE_DWA: begin
                o_sv_new   = w_dwa;
                o_ptr_next = w_sum_wrap[LW-1:0];
            end
            default: begin
                o_sv_new   = i_sv_cur;
                o_ptr_next = i_ptr;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dem_sv_sched.sv
`default_nettype none
// ============================================================================
// Module   : dem_sv_sched
// Brief    : 18-element DAC selection scheduler with one-entry level buffer.
// Revision : 1.0
// ============================================================================
module dem_sv_sched
    import dem_pkg::*;
(
    input  wire logic     clk,
    input  wire logic     rstn,
    dem_sv_sched_if.slave bus
);

    logic          r_full;
    logic [LW-1:0] r_lvl;
    logic [N-1:0]  r_sv;
    logic [LW-1:0] r_ptr;
    logic [LW-1:0] r_tr;
    logic          r_svv;
    logic          r_ovf;
    logic          r_udr;

    logic          w_consume;
    logic          w_ready;
    logic          w_accept;
    logic          w_lvl_over;
    logic [LW-1:0] w_lvl_clamped;
    logic          w_ovf_set;
    logic          w_udr_set;
    logic [N-1:0]  w_sv_new;
    logic [LW-1:0] w_ptr_next;
    logic [LW-1:0] w_tr;

    // Ready depends only on buffer state and the strobe, never on lvl_valid.
    assign w_consume     = bus.clk_en & r_full;
    assign w_ready       = ~r_full | bus.clk_en;
    assign w_accept      = bus.lvl_valid & w_ready;
    assign w_lvl_over    = (bus.lvl_in > LW'(N));
    assign w_lvl_clamped = w_lvl_over ? LW'(N) : bus.lvl_in;
    assign w_ovf_set     = w_accept & w_lvl_over;
    assign w_udr_set     = bus.clk_en & ~r_full;

    dwa_mask_gen u_mask (
        .i_ptr      (r_ptr),
        .i_lvl      (r_lvl),
        .i_mode     (bus.mode),
        .i_sv_cur   (r_sv),
        .o_sv_new   (w_sv_new),
        .o_ptr_next (w_ptr_next)
    );

    // In freeze the mask generator returns r_sv, so the rising count is zero.
    assign w_tr = popcount(~r_sv & w_sv_new);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_full <= 1'b0;
            r_lvl  <= '0;
        end else if (w_accept) begin
            r_full <= 1'b1;
            r_lvl  <= w_lvl_clamped;
        end else if (w_consume) begin
            r_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sv  <= '0;
            r_ptr <= '0;
            r_tr  <= '0;
            r_svv <= 1'b0;
        end else begin
            r_svv <= w_consume;
            if (w_consume) begin
                r_sv  <= w_sv_new;
                r_ptr <= w_ptr_next;
                r_tr  <= w_tr;
            end
        end
    end

    // A set event in the same cycle as err_clr keeps the flag asserted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ovf <= 1'b0;
            r_udr <= 1'b0;
        end else begin
            r_ovf <= w_ovf_set | (r_ovf & ~bus.err_clr);
            r_udr <= w_udr_set | (r_udr & ~bus.err_clr);
        end
    end

    assign bus.lvl_ready = w_ready;
    assign bus.SV        = r_sv;
    assign bus.sv_valid  = r_svv;
    assign bus.tr_cnt    = r_tr;
    assign bus.ptr       = r_ptr;
    assign bus.ovf_err   = r_ovf;
    assign bus.udr_err   = r_udr;

endmodule
`default_nettype wire
